mem_port_arbiter: RTL

//  Shares one single-port, variable-latency memory between the openmips instruction-fetch port and the load/store port.

---
 rtl/mem_port_arbiter.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port, variable-latency memory between
// the instruction-fetch port (IF) and the load/store port (LS). One access is
// in flight at a time; ties are broken round-robin and every access is bounded
// by a wait-timeout that completes it with err_o set.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_ack_o,
  input  logic              ls_req_i,
  input  logic              ls_we_i,
  input  logic [3:0]        ls_sel_i,
  input  logic [ADDR_W-1:0] ls_addr_i,
  input  logic [DATA_W-1:0] ls_wdata_i,
  output logic [DATA_W-1:0] ls_rdata_o,
  output logic              ls_ack_o,
  output logic              err_o,
  output logic              mem_ce_o,
  output logic              mem_we_o,
  output logic [3:0]        mem_sel_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_ack_i
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_IF   = 2'd1;
  localparam logic [1:0] S_LS   = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

  logic [1:0]        state_q,     state_d;
  logic              last_ls_q,   last_ls_d;   // 1: most recent grant went to LS
  logic [7:0]        wait_q,      wait_d;
  logic [DATA_W-1:0] if_rdata_q,  if_rdata_d;
  logic              if_ack_q,    if_ack_d;
  logic [DATA_W-1:0] ls_rdata_q,  ls_rdata_d;
  logic              ls_ack_q,    ls_ack_d;
  logic              err_q,       err_d;
  logic              mem_ce_q,    mem_ce_d;
  logic              mem_we_q,    mem_we_d;
  logic [3:0]        mem_sel_q,   mem_sel_d;
  logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

  // Next-state logic: arbitration in IDLE, ack/timeout handling during an access.
  always_comb begin
    state_d     = state_q;
    last_ls_d   = last_ls_q;
    wait_d      = wait_q;
    if_rdata_d  = if_rdata_q;
    ls_rdata_d  = ls_rdata_q;
    if_ack_d    = 1'b0;
    ls_ack_d    = 1'b0;
    err_d       = 1'b0;
    mem_ce_d    = mem_ce_q;
    mem_we_d    = mem_we_q;
    mem_sel_d   = mem_sel_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      S_IDLE: begin
        wait_d = '0;
        // LS wins when alone, or on a tie when IF had the previous grant.
        if (ls_req_i && (!if_req_i || !last_ls_q)) begin
          state_d     = S_LS;
          last_ls_d   = 1'b1;
          mem_ce_d    = 1'b1;
          mem_we_d    = ls_we_i;
          mem_sel_d   = ls_sel_i;
          mem_addr_d  = ls_addr_i;
          mem_wdata_d = ls_wdata_i;
        end else if (if_req_i) begin
          state_d     = S_IF;
          last_ls_d   = 1'b0;
          mem_ce_d    = 1'b1;
          mem_we_d    = 1'b0;
          mem_sel_d   = 4'hF;
          mem_addr_d  = if_addr_i;
          mem_wdata_d = '0;
        end
      end
      S_IF, S_LS: begin
        if (mem_ack_i) begin
          state_d  = S_RESP;
          mem_ce_d = 1'b0;
          if (state_q == S_LS) begin
            ls_rdata_d = mem_rdata_i;
            ls_ack_d   = 1'b1;
          end else begin
            if_rdata_d = mem_rdata_i;
            if_ack_d   = 1'b1;
          end
        end else if (wait_q == MAX_WAIT_C) begin
          state_d  = S_RESP;
          mem_ce_d = 1'b0;
          err_d    = 1'b1;
          if (state_q == S_LS) begin
            ls_rdata_d = '0;
            ls_ack_d   = 1'b1;
          end else begin
            if_rdata_d = '0;
            if_ack_d   = 1'b1;
          end
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      default: begin
        // Response cycle: ack is visible now, no new grant until IDLE.
        state_d = S_IDLE;
        wait_d  = '0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      last_ls_q   <= 1'b0;
      wait_q      <= '0;
      if_rdata_q  <= '0;
      if_ack_q    <= 1'b0;
      ls_rdata_q  <= '0;
      ls_ack_q    <= 1'b0;
      err_q       <= 1'b0;
      mem_ce_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_sel_q   <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      last_ls_q   <= last_ls_d;
      wait_q      <= wait_d;
      if_rdata_q  <= if_rdata_d;
      if_ack_q    <= if_ack_d;
      ls_rdata_q  <= ls_rdata_d;
      ls_ack_q    <= ls_ack_d;
      err_q       <= err_d;
      mem_ce_q    <= mem_ce_d;
      mem_we_q    <= mem_we_d;
      mem_sel_q   <= mem_sel_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign if_rdata_o  = if_rdata_q;
  assign if_ack_o    = if_ack_q;
  assign ls_rdata_o  = ls_rdata_q;
  assign ls_ack_o    = ls_ack_q;
  assign err_o       = err_q;
  assign mem_ce_o    = mem_ce_q;
  assign mem_we_o    = mem_we_q;
  assign mem_sel_o   = mem_sel_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;

endmodule
